reg_spill_fill: RTL and testbench

//  Context save/restore engine on the far side of the register-file port. It acts as an initiator

---
 rtl/reg_xfer_pkg.sv | 20 ++
 rtl/reg_spill_fill_if.sv | 33 +++
 rtl/reg_spill_fill.sv | 132 +++++++++++++
 tb/tb_reg_spill_fill.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_xfer_pkg.sv
// Shared types and default widths for the register spill/fill engine.
package reg_xfer_pkg;

    localparam int PW_DEF = 4;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } xfer_state_t;

    typedef enum logic {
        SPILL = 1'b0,
        FILL  = 1'b1
    } xfer_dir_t;

endpackage

// File: rtl/reg_spill_fill_if.sv
// Register-file and data-memory port bundle seen by the spill/fill engine.
interface reg_spill_fill_if #(
    parameter int PW = 4,
    parameter int DW = 8,
    parameter int AW = 8
);
    // rf_req asks for both ports; a word moves in every cycle where rf_req and rf_gnt
    // are both high, and rf_gnt may drop at any time without any word being lost.
    logic          rf_req;
    logic          rf_gnt;
    logic [PW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic          rf_wr_en;
    logic [PW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [AW-1:0] dm_addr;
    logic          dm_wr_en;
    logic [DW-1:0] dm_wr_data;
    logic [DW-1:0] dm_rd_data;

    modport master (
        output rf_req, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
               dm_addr, dm_wr_en, dm_wr_data,
        input  rf_gnt, rf_rd_data, dm_rd_data
    );

    modport slave (
        input  rf_req, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
               dm_addr, dm_wr_en, dm_wr_data,
        output rf_gnt, rf_rd_data, dm_rd_data
    );

endinterface

// File: rtl/reg_spill_fill.sv
// Context spill/fill engine: copies register runs to data memory and back, one word per granted cycle.
// Optional running XOR checksum enabled by defining SPILL_FILL_CHECKSUM_EN.
module reg_spill_fill
    import reg_xfer_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 dir,
    input  logic [PW-1:0]        first_reg,
    input  logic [PW:0]          count,
    input  logic [AW-1:0]        base_addr,
    output logic                 busy,
    output logic                 done,
    output logic [DW-1:0]        checksum,
    output xfer_state_t          fsm_state,
    reg_spill_fill_if.master     bus
);

    xfer_state_t state, state_nxt;
    xfer_dir_t   dir_q;
    logic [PW-1:0] idx;
    logic [AW-1:0] addr;
    logic [PW:0]   remaining;

    logic accept;
    logic move;

    assign accept    = (state == IDLE) && start;
    assign move      = (state == XFER) && bus.rf_gnt;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (count != '0) ? REQ : DONE;
            REQ:  if (bus.rf_gnt) state_nxt = XFER;
            XFER: if (bus.rf_gnt && remaining == (PW+1)'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Index and address wrap naturally at their register widths.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q     <= SPILL;
            idx       <= '0;
            addr      <= '0;
            remaining <= '0;
        end else if (accept) begin
            dir_q     <= xfer_dir_t'(dir);
            idx       <= first_reg;
            addr      <= base_addr;
            remaining <= count;
        end else if (move) begin
            idx       <= idx + 1'b1;
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        bus.rf_req     = 1'b0;
        bus.rf_rd_addr = '0;
        bus.rf_wr_en   = 1'b0;
        bus.rf_wr_addr = '0;
        bus.rf_wr_data = '0;
        bus.dm_addr    = '0;
        bus.dm_wr_en   = 1'b0;
        bus.dm_wr_data = '0;
        case (state)
            IDLE: busy = start && (count != '0);
            REQ: begin
                busy       = 1'b1;
                bus.rf_req = 1'b1;
            end
            XFER: begin
                busy        = 1'b1;
                bus.rf_req  = 1'b1;
                bus.dm_addr = addr;
                if (dir_q == SPILL) begin
                    bus.rf_rd_addr = idx;
                    bus.dm_wr_data = bus.rf_rd_data;
                    bus.dm_wr_en   = bus.rf_gnt;
                end else begin
                    bus.rf_wr_addr = idx;
                    bus.rf_wr_data = bus.dm_rd_data;
                    bus.rf_wr_en   = bus.rf_gnt;
                end
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef SPILL_FILL_CHECKSUM_EN
    logic [DW-1:0] chk_q;
    logic [DW-1:0] moved_word;

    assign moved_word = (dir_q == SPILL) ? bus.rf_rd_data : bus.dm_rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_q <= '0;
        end else if (accept) begin
            chk_q <= '0;
        end else if (move) begin
            chk_q <= chk_q ^ moved_word;
        end
    end

    assign checksum = chk_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_reg_spill_fill.sv
// Directed bench for reg_spill_fill: table of transfers, content table, grant-stall and reset sequences.
module tb_reg_spill_fill;
    import reg_xfer_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       dir;
    logic [3:0] first_reg;
    logic [4:0] count;
    logic [7:0] base_addr;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    xfer_state_t fsm_state;

    reg_spill_fill_if #(.PW(4), .DW(8), .AW(8)) bus ();

    reg_spill_fill #(.PW(4), .DW(8), .AW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dir       (dir),
        .first_reg (first_reg),
        .count     (count),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .fsm_state (fsm_state),
        .bus       (bus.master)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file and data memory models
    logic [7:0] rf  [16];
    logic [7:0] mem [256];

    assign bus.rf_rd_data = rf[bus.rf_rd_addr];
    assign bus.dm_rd_data = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (bus.rf_wr_en) rf[bus.rf_wr_addr] <= bus.rf_wr_data;
        if (bus.dm_wr_en) mem[bus.dm_addr] <= bus.dm_wr_data;
    end

    // free-running activity counters, sampled mid-cycle
    int cyc, done_cyc, n_done, n_busy, n_dm_wr, n_rf_wr, n_req;
    initial begin
        cyc = 0; done_cyc = 0; n_done = 0; n_busy = 0;
        n_dm_wr = 0; n_rf_wr = 0; n_req = 0;
    end
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (busy)         n_busy  = n_busy + 1;
        if (bus.dm_wr_en) n_dm_wr = n_dm_wr + 1;
        if (bus.rf_wr_en) n_rf_wr = n_rf_wr + 1;
        if (bus.rf_req)   n_req   = n_req + 1;
    end

    // scoreboard
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       dir;
        logic [3:0] first;
        logic [4:0] cnt;
        logic [7:0] base;
        int         lat;
        int         busy_cyc;
        int         dm_wr;
        int         rf_wr;
        logic       req;
        logic [7:0] chk;
    } vec_t;

    typedef struct {
        logic       is_mem;
        logic [7:0] addr;
        logic [7:0] val;
    } cell_t;

    function automatic logic [7:0] exp_chk(input logic [7:0] c);
`ifdef SPILL_FILL_CHECKSUM_EN
        return c;
`else
        return (c & 8'h00);
`endif
    endfunction

    int s_dm, s_rf, s_busy, s_done, s_req, start_cyc;

    task automatic launch(input logic d, input logic [3:0] f, input logic [4:0] c, input logic [7:0] b);
        @(posedge clk); #1;
        start = 1'b1; dir = d; first_reg = f; count = c; base_addr = b;
        s_dm = n_dm_wr; s_rf = n_rf_wr; s_busy = n_busy; s_done = n_done; s_req = n_req;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        // scramble inputs that must be ignored once latched
        start = 1'b0; dir = ~d; first_reg = 4'hf; count = 5'd7; base_addr = 8'hcc;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (n_done != s_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        launch(v.dir, v.first, v.cnt, v.base);
        wait_done(tag);
        check({tag, "_latency"},  32'(done_cyc - start_cyc), 32'(v.lat));
        check({tag, "_busy_cyc"}, 32'(n_busy - s_busy),      32'(v.busy_cyc));
        check({tag, "_dm_wr"},    32'(n_dm_wr - s_dm),       32'(v.dm_wr));
        check({tag, "_rf_wr"},    32'(n_rf_wr - s_rf),       32'(v.rf_wr));
        check({tag, "_req_seen"}, 32'(n_req != s_req),       32'(v.req));
        check({tag, "_done_once"},32'(n_done - s_done),      32'd1);
        check({tag, "_checksum"}, 32'(checksum),             32'(exp_chk(v.chk)));
    endtask

    vec_t  vecs  [5];
    cell_t cells [16];

    initial begin
        vecs[0] = '{1'b0, 4'd2,  5'd4,  8'h40, 6,  6,  4,  0, 1'b1, 8'h44};
        vecs[1] = '{1'b1, 4'd0,  5'd3,  8'h10, 5,  5,  0,  3, 1'b1, 8'ha3};
        vecs[2] = '{1'b0, 4'd14, 5'd4,  8'hfe, 6,  6,  4,  0, 1'b1, 8'h10};
        vecs[3] = '{1'b0, 4'd5,  5'd0,  8'h80, 1,  0,  0,  0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 4'd3,  5'd16, 8'h80, 18, 18, 16, 0, 1'b1, 8'he7};

        cells[0]  = '{1'b1, 8'h40, 8'h11};
        cells[1]  = '{1'b1, 8'h41, 8'h22};
        cells[2]  = '{1'b1, 8'h42, 8'h33};
        cells[3]  = '{1'b1, 8'h43, 8'h44};
        cells[4]  = '{1'b0, 8'h00, 8'ha0};
        cells[5]  = '{1'b0, 8'h01, 8'ha1};
        cells[6]  = '{1'b0, 8'h02, 8'ha2};
        cells[7]  = '{1'b1, 8'hfe, 8'he4};
        cells[8]  = '{1'b1, 8'hff, 8'hf5};
        cells[9]  = '{1'b1, 8'h00, 8'ha0};
        cells[10] = '{1'b1, 8'h01, 8'ha1};
        cells[11] = '{1'b1, 8'h80, 8'h22};
        cells[12] = '{1'b1, 8'h8b, 8'he4};
        cells[13] = '{1'b1, 8'h8f, 8'ha2};
        cells[14] = '{1'b1, 8'h83, 8'h00};
        cells[15] = '{1'b1, 8'h8d, 8'ha0};

        start = 1'b0; dir = 1'b0; first_reg = '0; count = '0; base_addr = '0;
        bus.rf_gnt = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        for (int i = 0; i < 16; i++)  rf[i]  <= 8'h00;
        #1;
        mem[8'h10] <= 8'ha0; mem[8'h11] <= 8'ha1; mem[8'h12] <= 8'ha2;
        mem[8'h83] <= 8'hff; mem[8'h63] <= 8'h5a;
        rf[2] <= 8'h11; rf[3] <= 8'h22; rf[4] <= 8'h33; rf[5] <= 8'h44;
        rf[14] <= 8'he4; rf[15] <= 8'hf5;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_done",     32'(done),         32'd0);
        check("rst_rf_req",   32'(bus.rf_req),   32'd0);
        check("rst_state",    32'(fsm_state),    32'(IDLE));
        check("rst_checksum", 32'(checksum),     32'd0);
        check("rst_dm_wr_en", 32'(bus.dm_wr_en), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            if (cells[i].is_mem)
                check($sformatf("mem_%0h", cells[i].addr), 32'(mem[cells[i].addr]), 32'(cells[i].val));
            else
                check($sformatf("rf_%0d", cells[i].addr), 32'(rf[cells[i].addr[3:0]]), 32'(cells[i].val));
        end

        // grant stall for three cycles after the second word
        rf[8] <= 8'h81; rf[9] <= 8'h82; rf[10] <= 8'h83; rf[11] <= 8'h84; rf[12] <= 8'h85;
        launch(1'b0, 4'd8, 5'd5, 8'h20);
        for (int k = 0; k < 20; k++) begin
            if (n_dm_wr - s_dm == 2) break;
            @(posedge clk); #1;
        end
        bus.rf_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_no_writes", 32'(n_dm_wr - s_dm), 32'd2);
        check("stall_req_held",  32'(bus.rf_req),     32'd1);
        bus.rf_gnt = 1'b1;
        wait_done("stall");
        check("stall_latency", 32'(done_cyc - start_cyc), 32'd10);
        check("stall_dm_wr",   32'(n_dm_wr - s_dm),       32'd5);
        check("stall_checksum",32'(checksum),             32'(exp_chk(8'h81)));
        for (int i = 0; i < 5; i++) begin
            logic [7:0] e;
            e = 8'h81 + 8'(i);
            check($sformatf("stall_mem_%0d", i), 32'(mem[8'h20 + 8'(i)]), 32'(e));
        end

        // asynchronous reset in the middle of a spill
        launch(1'b0, 4'd0, 5'd8, 8'h60);
        for (int k = 0; k < 20; k++) begin
            if (n_dm_wr - s_dm == 3) break;
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        check("arst_state",    32'(fsm_state),      32'(IDLE));
        check("arst_rf_req",   32'(bus.rf_req),     32'd0);
        check("arst_busy",     32'(busy),           32'd0);
        check("arst_dm_wr_en", 32'(bus.dm_wr_en),   32'd0);
        check("arst_dm_addr",  32'(bus.dm_addr),    32'd0);
        check("arst_rd_addr",  32'(bus.rf_rd_addr), 32'd0);
        check("arst_checksum", 32'(checksum),       32'd0);
        #1;
        reset_n = 1'b1;
        check("arst_mem60", 32'(mem[8'h60]), 32'ha0);
        check("arst_mem62", 32'(mem[8'h62]), 32'ha2);
        check("arst_mem63", 32'(mem[8'h63]), 32'h5a);

        run_vec('{1'b0, 4'd14, 5'd2, 8'h70, 4, 4, 2, 0, 1'b1, 8'h11}, "post_rst");
        check("post_rst_mem70", 32'(mem[8'h70]), 32'he4);
        check("post_rst_mem71", 32'(mem[8'h71]), 32'hf5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
